// File: rtl/custom_ip_reg_pkg.sv
// Shared types and default sizes for the custom IP register-channel arbiter.
package custom_ip_reg_pkg;

    localparam int unsigned DefDW      = 32;
    localparam int unsigned DefAW      = 2;
    localparam int unsigned DefNumRegs = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWack,
        StRead,
        StErr,
        StResp
    } state_e;

    // Response payload; sized by the package default data width.
    typedef struct packed {
        logic [DefDW-1:0] rdata;
        logic             err;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above the pointer wins, with wrap-around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Upper pass covers [ptr, NUM_REQ), lower pass wraps to [0, ptr).
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (en_i && !valid_o && req_i[i] && (IW'(i) >= ptr_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (en_i && !valid_o && req_i[i] && (IW'(i) < ptr_i)) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/custom_ip_reg_arbiter.sv
// Serializes register accesses from several requesters onto the IP register channel,
// with per-access timeout and out-of-range error responses.
module custom_ip_reg_arbiter
    import custom_ip_reg_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_REGS = DefNumRegs,
    parameter int unsigned DW       = DefDW,
    parameter int unsigned AW       = DefAW,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ-1:0]     we_i,
    input  logic [NUM_REQ*AW-1:0]  addr_i,
    input  logic [NUM_REQ*DW-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     rvalid_o,
    output logic [DW-1:0]          rdata_o,
    output logic                   err_o,
    output logic [NUM_REGS-1:0]    ip_wr_en_o,
    output logic [DW-1:0]          ip_wr_data_o,
    input  logic [NUM_REGS-1:0]    ip_wr_ack_i,
    input  logic [NUM_REGS*DW-1:0] ip_rd_data_i,
    input  logic [NUM_REGS-1:0]    ip_rd_valid_i
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e          r_state, w_state_d;
    logic [IW-1:0]   r_ptr, w_ptr_d;
    logic [IW-1:0]   r_idx, w_idx_d;
    logic [AW-1:0]   r_addr, w_addr_d;
    logic [DW-1:0]   r_wdata, w_wdata_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    resp_t           r_resp, w_resp_d;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IW-1:0]       w_win;
    logic                w_any;
    logic                w_req_we;
    logic [AW-1:0]       w_req_addr;
    logic [DW-1:0]       w_req_wdata;
    logic [NUM_REGS-1:0] w_sel;
    logic                w_wr_ack;
    logic                w_rd_vld;
    logic [DW-1:0]       w_rd_data;
    logic                w_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (r_ptr),
        .en_i    (r_state == StIdle),
        .gnt_o   (w_gnt),
        .idx_o   (w_win),
        .valid_o (w_any)
    );

    // Payload of the winning requester.
    always_comb begin
        w_req_we    = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_req_we    = we_i[i];
                w_req_addr  = addr_i[i*AW +: AW];
                w_req_wdata = wdata_i[i*DW +: DW];
            end
        end
    end

    // Decode of the latched register index (only reached with an in-range index).
    always_comb begin
        w_sel     = '0;
        w_wr_ack  = 1'b0;
        w_rd_vld  = 1'b0;
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_addr == AW'(i)) begin
                w_sel[i]  = 1'b1;
                w_wr_ack  = ip_wr_ack_i[i];
                w_rd_vld  = ip_rd_valid_i[i];
                w_rd_data = ip_rd_data_i[i*DW +: DW];
            end
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_idx_d      = r_idx;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_cnt_d      = r_cnt;
        w_resp_d     = r_resp;
        gnt_o        = '0;
        rvalid_o     = '0;
        rdata_o      = '0;
        err_o        = 1'b0;
        ip_wr_en_o   = '0;
        ip_wr_data_o = '0;

        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (w_any) begin
                    gnt_o     = w_gnt;
                    w_idx_d   = w_win;
                    w_addr_d  = w_req_addr;
                    w_wdata_d = w_req_wdata;
                    w_resp_d  = '0;
                    w_ptr_d   = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    if (32'(w_req_addr) >= NUM_REGS) begin
                        w_state_d = StErr;
                    end else if (w_req_we) begin
                        w_state_d = StWrite;
                    end else begin
                        w_state_d = StRead;
                    end
                end
            end
            StWrite: begin
                ip_wr_en_o   = w_sel;
                ip_wr_data_o = r_wdata;
                w_state_d    = StWack;
            end
            StWack: begin
                if (w_wr_ack) begin
                    w_resp_d  = '{rdata: '0, err: 1'b0};
                    w_state_d = StResp;
                end else if (w_timeout) begin
                    w_resp_d  = '{rdata: '0, err: 1'b1};
                    w_state_d = StResp;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StRead: begin
                if (w_rd_vld) begin
                    w_resp_d  = '{rdata: w_rd_data, err: 1'b0};
                    w_state_d = StResp;
                end else if (w_timeout) begin
                    w_resp_d  = '{rdata: '0, err: 1'b1};
                    w_state_d = StResp;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StErr: begin
                w_resp_d  = '{rdata: '0, err: 1'b1};
                w_state_d = StResp;
            end
            StResp: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    rvalid_o[i] = (r_idx == IW'(i));
                end
                rdata_o   = r_resp.rdata;
                err_o     = r_resp.err;
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_idx   <= w_idx_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_cnt   <= w_cnt_d;
            r_resp  <= w_resp_d;
        end
    end

endmodule

// File: doc/custom_ip_reg_arbiter.md
Name: custom_ip_reg_arbiter

Overview:
- Shares the register-to-hardware channel of the custom AXI IP register bank between NUM_REQ requesters (e.g. core register interface, debug, DMA).
- Serializes accesses with a round-robin arbiter and drives one-hot per-register write enables plus write data.
- Waits for the IP's per-register write acknowledge or read-valid flag and returns a response to the winning requester.
- Timeout and out-of-range protection produce an error response instead of a hang.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- NUM_REGS, 3, number of IP registers.
- DW, 32, register data width.
- AW, 2, register address width ($clog2(NUM_REGS), min 1).
- TIMEOUT, 16, max cycles to wait for IP ack/valid (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  access request per requester.
- we_i  in  NUM_REQ  1 = write, 0 = read.
- addr_i  in  NUM_REQ*AW  register index per requester.
- wdata_i  in  NUM_REQ*DW  write data per requester.
- gnt_o  out  NUM_REQ  one-cycle grant pulse, one-hot.
- rvalid_o  out  NUM_REQ  one-cycle response pulse, one-hot.
- rdata_o  out  DW  read data (shared, valid with rvalid_o).
- err_o  out  1  error flag (valid with rvalid_o).
- ip_wr_en_o  out  NUM_REGS  one-hot write enable to IP.
- ip_wr_data_o  out  DW  write data to IP.
- ip_wr_ack_i  in  NUM_REGS  per-register write acknowledge from IP.
- ip_rd_data_i  in  NUM_REGS*DW  per-register read data from IP.
- ip_rd_valid_i  in  NUM_REGS  per-register read-data-ready flag from IP.

Behaviour:
- Reset state:
  - All outputs 0; FSM in IDLE; round-robin pointer 0 (requester 0 has top priority first); timeout counter 0.
  - Reset mid-transaction aborts it. No response is issued, and ip_wr_en_o drops immediately (async).
- IDLE:
  - If any req_i is set, pick the first set bit scanning from the pointer upward with wrap-around.
  - Pulse gnt_o[winner] for that cycle.
  - Latch we, addr, wdata and winner index; set pointer = winner+1 (mod NUM_REQ).
  - Next state: ERR if addr >= NUM_REGS, else WRITE if we, else READ.
- WRITE: ip_wr_en_o[addr]=1 and ip_wr_data_o=wdata for exactly one cycle -> WACK.
- WACK:
  - ip_wr_ack_i[addr]=1 -> RESP with err=0.
  - Otherwise increment the counter; when the counter reaches TIMEOUT-1 without ack, go to RESP with err=1.
  - Acks on other indices are ignored.
- READ:
  - ip_rd_valid_i[addr]=1 -> capture ip_rd_data_i slice [addr*DW +: DW] into rdata, go to RESP with err=0.
  - Same timeout rule as WACK; on timeout rdata=0 and err=1.
- ERR: one cycle, rdata=0, err=1 -> RESP.
- RESP:
  - rvalid_o[winner]=1 with rdata_o/err_o for one cycle -> IDLE.
  - Counter clears; rdata_o/err_o return to 0 outside RESP.
- Latency:
  - Write with ack already high: gnt at cycle T, ip_wr_en at T+1, ack sampled T+2, rvalid at T+3.
  - Read with valid already high: gnt T, valid sampled T+1, rvalid T+2.
- Handshake rules:
  - A requester holds req_i and its payload stable until gnt_o; it may drop req_i after grant.
  - No grant is issued outside IDLE, so only one transaction is outstanding.
  - A requester still asserting req in the RESP cycle is re-arbitrated in the following IDLE cycle.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- Requests arriving while busy are held off; there is no queueing inside the block.

Decomposition:
- Package custom_ip_reg_pkg:
  - state enum (IDLE, WRITE, WACK, READ, ERR, RESP);
  - default widths DW, AW, NUM_REGS;
  - a response struct {rdata, err}.
- Sub-module rr_arbiter:
  - parameter NUM_REQ; inputs req vector, pointer, enable;
  - output one-hot grant and winner index;
  - combinational, reused elsewhere.

Test Plan:
- Single write, req0 addr=1 wdata=0xDEADBEEF, IP acks next cycle:
  - gnt_o=01 at T, ip_wr_en_o=010 with data 0xDEADBEEF at T+1, rvalid_o=01 at T+3, err=0.
- Read req1 addr=2, ip_rd_data slice2=0x12345678, valid high:
  - gnt_o=10 at T, rvalid_o=10 at T+2, rdata_o=0x12345678, err=0.
- Both requesters hold req continuously for 4 transactions (acks immediate):
  - grants alternate 0,1,0,1; never two bits of gnt_o set together.
- Write addr=0 with ip_wr_ack_i held 0, TIMEOUT=16:
  - rvalid with err=1 after 16 WACK cycles; FSM returns to IDLE and serves the next request.
- Read addr=3 (>= NUM_REGS):
  - no ip_wr_en_o or IP access; rvalid at T+2 with err=1, rdata=0.
- rst_ni asserted during WACK:
  - all outputs 0 immediately; after release, req1 and req0 both high -> requester 0 granted first.
